// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access codes,
// access sizes, lock-state encoding and access-code helpers.
package dmem_pkg;

  localparam logic [3:0] OP_LB  = 4'b1000;
  localparam logic [3:0] OP_LH  = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SB  = 4'b1011;
  localparam logic [3:0] OP_LBU = 4'b1100;
  localparam logic [3:0] OP_LHU = 4'b1101;
  localparam logic [3:0] OP_SH  = 4'b1110;
  localparam logic [3:0] OP_SW  = 4'b1111;

  localparam int unsigned SZ_B = 1;
  localparam int unsigned SZ_H = 2;
  localparam int unsigned SZ_W = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED1  = 1'b1
  } lock_state_e;

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Every active code that is not a store is a load.
  function automatic logic op_is_load(input logic [3:0] op);
    return op[3] && !op_is_store(op);
  endfunction

  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'(SZ_B);
      OP_LH, OP_LHU, OP_SH: return 3'(SZ_H);
      OP_LW, OP_SW:         return 3'(SZ_W);
      default:              return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker with a port-1 exclusive-ownership override.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       lock,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock)
      gnt[1] = req[1];
    else if (&req)
      gnt = last_gnt ? 2'b01 : 2'b10;
    else
      gnt = req;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data memory between the LSU (port 0) and the
// loader/debug master (port 1). Optional access check: define DMEM_ALIGN_CHECK_EN.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              p0_req,
  input  logic [3:0]        p0_op,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic [3:0]        p1_op,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  input  logic              p1_lock,
  output logic [3:0]        m_rwen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  lock_state_e       state;
  logic              last_gnt;
  logic              locked_now;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic [3:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              fault;
  logic [DATA_W-1:0] rsp_data;

  // The lock is released in the same cycle p1_lock falls, not one cycle later.
  assign locked_now = (state == LOCKED1) && p1_lock;

  dmem_rr_pick u_pick (
    .req      ({p1_req, p0_req}),
    .last_gnt (last_gnt),
    .lock     (locked_now),
    .gnt      (pick)
  );

  assign gnt    = RESET ? 2'b00 : pick;
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[1]) begin
      sel_op    = p1_op;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else if (gnt[0]) begin
      sel_op    = p0_op;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic [2:0]      sel_size;
  logic [ADDR_W:0] end_addr;

  always_comb begin
    sel_size = op_size(sel_op);
    end_addr = {1'b0, sel_addr} + (ADDR_W+1)'(sel_size);
    fault    = (sel_size == 3'(SZ_H) && sel_addr[0])
            || (sel_size == 3'(SZ_W) && sel_addr[1:0] != 2'b00)
            || (sel_size != 3'd0 && end_addr > (ADDR_W+1)'(MEM_BYTES));
  end
`else
  assign fault = 1'b0;
`endif

  assign m_rwen  = fault ? 4'b0000 : sel_op;
  assign m_addr  = sel_addr;
  assign m_wdata = sel_wdata;

  assign rsp_data = (op_is_load(sel_op) && !fault) ? m_rdata : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= UNLOCKED;
      last_gnt  <= 1'b1;
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_err    <= 1'b0;
    end else begin
      if (|gnt)
        last_gnt <= gnt[1];

      if (state == UNLOCKED) begin
        if (gnt[1] && p1_lock)
          state <= LOCKED1;
      end else if (!p1_lock) begin
        state <= UNLOCKED;
      end

      p0_rvalid <= gnt[0];
      p0_rdata  <= gnt[0] ? rsp_data : '0;
      p0_err    <= gnt[0] && fault;
      p1_rvalid <= gnt[1];
      p1_rdata  <= gnt[1] ? rsp_data : '0;
      p1_err    <= gnt[1] && fault;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-addressed memory model.
module tb_dmem_port_arbiter;

  localparam int unsigned MEM_BYTES = 524288;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        p0_req, p1_req, p1_lock;
  logic [3:0]  p0_op, p1_op;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  m_rwen;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .p0_req    (p0_req),
    .p0_op     (p0_op),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (p1_req),
    .p1_op     (p1_op),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .p1_lock   (p1_lock),
    .m_rwen    (m_rwen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata)
  );

  always #5 CLK = ~CLK;

  // Little-endian memory model, 4 KiB window, loads sign/zero-extend here.
  bit   [7:0] mem [0:4095];
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    rb0 = mem[m_addr[11:0]];
    rb1 = mem[m_addr[11:0] + 12'd1];
    rb2 = mem[m_addr[11:0] + 12'd2];
    rb3 = mem[m_addr[11:0] + 12'd3];
    case (m_rwen)
      4'b1000: m_rdata = {{24{rb0[7]}}, rb0};
      4'b1001: m_rdata = {{16{rb1[7]}}, rb1, rb0};
      4'b1010: m_rdata = {rb3, rb2, rb1, rb0};
      4'b1100: m_rdata = {24'h0, rb0};
      4'b1101: m_rdata = {16'h0, rb1, rb0};
      default: m_rdata = '0;
    endcase
  end

  always @(posedge CLK) begin
    case (m_rwen)
      4'b1011: mem[m_addr[11:0]] <= m_wdata[7:0];
      4'b1110: begin
        mem[m_addr[11:0]]         <= m_wdata[7:0];
        mem[m_addr[11:0] + 12'd1] <= m_wdata[15:8];
      end
      4'b1111: begin
        mem[m_addr[11:0]]         <= m_wdata[7:0];
        mem[m_addr[11:0] + 12'd1] <= m_wdata[15:8];
        mem[m_addr[11:0] + 12'd2] <= m_wdata[23:16];
        mem[m_addr[11:0] + 12'd3] <= m_wdata[31:24];
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set0(input logic req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    p0_req = req; p0_op = op; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    p1_req = req; p1_op = op; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    RESET = 1'b1;
    p1_lock = 1'b0;
    set0(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF);
    set1(1'b0, 4'b0000, 32'h0, 32'h0);
    #2;
    check_eq("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check_eq("rst_m_rwen", 32'(m_rwen), 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check_eq("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    tick(); tick();
    RESET = 1'b0;

    // SW then LW at 0x100
    #1;
    check_eq("sw_p0_gnt", 32'(p0_gnt), 32'd1);
    check_eq("sw_p1_gnt", 32'(p1_gnt), 32'd0);
    check_eq("sw_m_rwen", 32'(m_rwen), 32'hF);
    check_eq("sw_m_addr", m_addr, 32'h100);
    check_eq("sw_m_wdata", m_wdata, 32'hDEADBEEF);
    tick();
    check_eq("sw_rvalid", 32'(p0_rvalid), 32'd1);
    check_eq("sw_rdata", p0_rdata, 32'd0);
    check_eq("sw_err", 32'(p0_err), 32'd0);
    check_eq("sw_p1_rvalid", 32'(p1_rvalid), 32'd0);
    set0(1'b1, 4'b1010, 32'h100, 32'h0);
    #1;
    check_eq("lw_p0_gnt", 32'(p0_gnt), 32'd1);
    check_eq("lw_m_rwen", 32'(m_rwen), 32'hA);
    tick();
    check_eq("lw_rvalid", 32'(p0_rvalid), 32'd1);
    check_eq("lw_rdata", p0_rdata, 32'hDEADBEEF);
    set0(1'b0, 4'b0000, 32'h0, 32'h0);
    tick();
    check_eq("rvalid_pulse", 32'(p0_rvalid), 32'd0);
    check_eq("idle_m_rwen", 32'(m_rwen), 32'd0);

    // SB 0x80 @0x203, LB and LBU readback
    set0(1'b1, 4'b1011, 32'h203, 32'h00000080);
    #1;
    check_eq("sb_m_rwen", 32'(m_rwen), 32'hB);
    tick();
    set0(1'b1, 4'b1000, 32'h203, 32'h0);
    tick();
    check_eq("lb_rdata", p0_rdata, 32'hFFFFFF80);
    set0(1'b1, 4'b1100, 32'h203, 32'h0);
    tick();
    check_eq("lbu_rdata", p0_rdata, 32'h00000080);
    set0(1'b0, 4'b0000, 32'h0, 32'h0);

    // No-op code is still granted and acknowledged with zero data
    set1(1'b1, 4'b0101, 32'h40, 32'h1234);
    #1;
    check_eq("nop_p1_gnt", 32'(p1_gnt), 32'd1);
    check_eq("nop_m_rwen", 32'(m_rwen), 32'h5);
    tick();
    check_eq("nop_rvalid", 32'(p1_rvalid), 32'd1);
    check_eq("nop_rdata", p1_rdata, 32'd0);
    set1(1'b0, 4'b0000, 32'h0, 32'h0);

    // Reset right after a p0 grant drops the response; p0 wins first afterwards
    set0(1'b1, 4'b1010, 32'h100, 32'h0);
    #1;
    check_eq("pre_rst_gnt", 32'(p0_gnt), 32'd1);
    @(posedge CLK);
    RESET = 1'b1;
    #1;
    check_eq("rst_drop_rvalid", 32'(p0_rvalid), 32'd0);
    check_eq("rst_drop_rdata", p0_rdata, 32'd0);
    set1(1'b1, 4'b1010, 32'h104, 32'h0);
    #1;
    check_eq("rst_both_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
    tick();
    check_eq("rst_hold_rvalid", 32'(p0_rvalid), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_p0_gnt", 32'(p0_gnt), 32'(i % 2 == 0));
      check_eq("rr_p1_gnt", 32'(p1_gnt), 32'(i % 2 == 1));
      check_eq("rr_m_addr", m_addr, (i % 2 == 0) ? 32'h100 : 32'h104);
      tick();
      check_eq("rr_p0_rvalid", 32'(p0_rvalid), 32'(i % 2 == 0));
      check_eq("rr_p0_rdata", p0_rdata, (i % 2 == 0) ? 32'hDEADBEEF : 32'h0);
    end

    // p0 alone once so p1 wins the first contended lock cycle
    set1(1'b0, 4'b0000, 32'h0, 32'h0);
    #1;
    check_eq("pre_lock_p0_gnt", 32'(p0_gnt), 32'd1);
    tick();

    for (int i = 0; i < 4; i++) begin
      set1(1'b1, 4'b1111, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
      p1_lock = 1'b1;
      #1;
      check_eq("lock_p0_gnt", 32'(p0_gnt), 32'd0);
      check_eq("lock_p1_gnt", 32'(p1_gnt), 32'd1);
      tick();
      check_eq("lock_p1_rvalid", 32'(p1_rvalid), 32'd1);
    end
    set1(1'b0, 4'b0000, 32'h0, 32'h0);
    p1_lock = 1'b0;
    #1;
    check_eq("unlock_p0_gnt", 32'(p0_gnt), 32'd1);
    tick();
    check_eq("unlock_p0_rvalid", 32'(p0_rvalid), 32'd1);
    set0(1'b0, 4'b0000, 32'h0, 32'h0);

    set1(1'b1, 4'b1010, 32'h30C, 32'h0);
    #1;
    check_eq("rd_p1_gnt", 32'(p1_gnt), 32'd1);
    tick();
    check_eq("rd_p1_rdata", p1_rdata, 32'h000000A3);
    set1(1'b0, 4'b0000, 32'h0, 32'h0);

    // p1_lock without p1_req while unlocked must not lock
    p1_lock = 1'b1;
    set0(1'b1, 4'b1010, 32'h100, 32'h0);
    #1;
    check_eq("lock_noreq_gnt_a", 32'(p0_gnt), 32'd1);
    tick();
    check_eq("lock_noreq_gnt_b", 32'(p0_gnt), 32'd1);
    p1_lock = 1'b0;
    set0(1'b0, 4'b0000, 32'h0, 32'h0);
    tick();

`ifdef DMEM_ALIGN_CHECK_EN
    set0(1'b1, 4'b1010, 32'h102, 32'h0);
    #1;
    check_eq("mis_lw_gnt", 32'(p0_gnt), 32'd1);
    check_eq("mis_lw_m_rwen", 32'(m_rwen), 32'd0);
    tick();
    check_eq("mis_lw_rvalid", 32'(p0_rvalid), 32'd1);
    check_eq("mis_lw_err", 32'(p0_err), 32'd1);
    check_eq("mis_lw_rdata", p0_rdata, 32'd0);
    set0(1'b1, 4'b1111, MEM_BYTES - 2, 32'h55AA55AA);
    #1;
    check_eq("oob_sw_m_rwen", 32'(m_rwen), 32'd0);
    tick();
    check_eq("oob_sw_err", 32'(p0_err), 32'd1);
    check_eq("oob_mem_ffe", {24'h0, mem[12'hFFE]}, 32'd0);
    check_eq("oob_mem_fff", {24'h0, mem[12'hFFF]}, 32'd0);
    set0(1'b0, 4'b0000, 32'h0, 32'h0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
